// File: rtl/if_id_queue_pkg.sv
// if_id_queue_pkg: shared widths and default sizing for the IF/ID instruction queue
package if_id_queue_pkg;
  localparam int INST_ADDR_BUS_W = 32;
  localparam int INST_BUS_W = 32;
  localparam int QUEUE_DEPTH = 4;
endpackage

// File: rtl/if_id_queue_fifo_mem.sv
// if_id_queue_fifo_mem: DEPTH x W register array, one write port, asynchronous read port
module if_id_queue_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int W = 64
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [W-1:0]             wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [W-1:0]             rdata_o
);
  logic [W-1:0] mem_q [DEPTH];
  // contents are left unreset; the queue masks reads with its valid flag
  always_ff @(posedge clk)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/if_id_queue.sv
// if_id_queue: DEPTH-entry IF->ID instruction FIFO with flush, rdy gating and zero bubble when empty
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = QUEUE_DEPTH,
  parameter int ADDR_W = INST_ADDR_BUS_W,
  parameter int INST_W = INST_BUS_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       flush,
  input  logic                       if_valid,
  input  logic [ADDR_W-1:0]          if_pc,
  input  logic [INST_W-1:0]          if_inst,
  output logic                       if_ready,
  output logic                       id_valid,
  output logic [ADDR_W-1:0]          id_pc,
  output logic [INST_W-1:0]          id_inst,
  input  logic                       id_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic push, pop, clr;
  logic [ADDR_W+INST_W-1:0] rdata;
  assign count = count_q;
  assign if_ready = count_q != CW'(DEPTH);
  assign id_valid = count_q != '0;
  assign id_pc = id_valid ? rdata[ADDR_W+INST_W-1:INST_W] : '0;
  assign id_inst = id_valid ? rdata[INST_W-1:0] : '0;
  // handshakes are gated by rdy and killed by flush/rst; flush only takes effect while rdy is high
  always_comb begin
    push = if_valid & if_ready & rdy & ~flush & ~rst;
    pop = id_valid & id_ready & rdy & ~flush & ~rst;
    clr = rdy & flush;
    wr_d = clr ? '0 : wr_q + AW'(push);
    rd_d = clr ? '0 : rd_q + AW'(pop);
    count_d = clr ? '0 : count_q + CW'(push) - CW'(pop);
  end
  // pointer and occupancy registers, reset wins over everything
  always_ff @(posedge clk)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
    end
  if_id_queue_fifo_mem #(.DEPTH(DEPTH), .W(ADDR_W + INST_W)) u_fifo_mem (
    .clk    (clk),
    .we_i   (push),
    .waddr_i(wr_q),
    .wdata_i({if_pc, if_inst}),
    .raddr_i(rd_q),
    .rdata_o(rdata)
  );
endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: directed + random stimulus checked against a queue-based model
module tb_if_id_queue;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 1, rdy = 1, flush = 0, if_valid = 0, id_ready = 0;
  logic [31:0] if_pc = 0, if_inst = 0, id_pc, id_inst;
  logic if_ready, id_valid;
  logic [2:0] count;
  int passed = 0, total = 0;
  logic [63:0] mq [$];
  int pushed = 0, popped = 0;

  if_id_queue #(.DEPTH(DEPTH), .ADDR_W(32), .INST_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .if_valid(if_valid), .if_pc(if_pc),
    .if_inst(if_inst), .if_ready(if_ready), .id_valid(id_valid), .id_pc(id_pc),
    .id_inst(id_inst), .id_ready(id_ready), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // drive one cycle, advance the model at the edge, then compare all outputs
  task automatic cyc(input logic v, input logic [31:0] pc, input logic dr,
                     input logic fl, input logic r, input logic rs);
    logic [63:0] h;
    @(negedge clk);
    if_valid = v; if_pc = pc; if_inst = $urandom; id_ready = dr; flush = fl; rdy = r; rst = rs;
    @(posedge clk);
    if (rs) mq.delete();
    else if (r && fl) mq.delete();
    else if (r) begin
      bit can_push = v && mq.size() < DEPTH;
      if (dr && mq.size() > 0) begin void'(mq.pop_front()); popped++; end
      if (can_push) begin mq.push_back({if_pc, if_inst}); pushed++; end
    end
    #1;
    h = mq.size() > 0 ? mq[0] : 64'd0;
    chk("count", 64'(count), 64'(mq.size()));
    chk("id_valid", 64'(id_valid), 64'(mq.size() > 0));
    chk("if_ready", 64'(if_ready), 64'(mq.size() < DEPTH));
    chk("id_pc", 64'(id_pc), 64'(h[63:32]));
    chk("id_inst", 64'(id_inst), 64'(h[31:0]));
  endtask

  initial begin
    logic [31:0] pc_hold, inst_hold;
    int n;
    cyc(1, 32'h10, 0, 0, 1, 1);
    cyc(1, 32'h14, 0, 0, 1, 1);
    chk("rst_count", 64'(count), 0);
    chk("rst_if_ready", 64'(if_ready), 1);
    chk("rst_id_pc", 64'(id_pc), 0);
    for (int i = 0; i < 5; i++) cyc(1, 32'(i * 4), 0, 0, 1, 0);
    chk("full_count", 64'(count), 4);
    chk("full_if_ready", 64'(if_ready), 0);
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", 64'(id_pc), 64'(i * 4));
      cyc(0, 0, 1, 0, 1, 0);
    end
    chk("drain_bubble", 64'(id_valid), 0);
    for (int i = 0; i < 20; i++) begin
      cyc(1, 32'h100 + 32'(i * 4), 1, 0, 1, 0);
      chk("stream_count", 64'(count), 1);
      chk("stream_lag", 64'(id_pc), 64'(32'h100 + 32'(i * 4)));
    end
    cyc(0, 0, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(1, 32'h20 + 32'(i * 4), 0, 0, 1, 0);
    cyc(1, 32'h40, 1, 1, 1, 0);
    chk("flush_count", 64'(count), 0);
    chk("flush_if_ready", 64'(if_ready), 1);
    cyc(1, 32'h80, 0, 0, 1, 0);
    chk("redirect_head", 64'(id_pc), 64'h80);
    cyc(1, 32'h84, 0, 0, 1, 0);
    pc_hold = id_pc; inst_hold = id_inst;
    for (int i = 0; i < 5; i++) cyc(1, 32'h200, 1, i[0], 0, 0);
    chk("rdy_count", 64'(count), 2);
    chk("rdy_pc", 64'(id_pc), 64'(pc_hold));
    chk("rdy_inst", 64'(id_inst), 64'(inst_hold));
    cyc(0, 0, 1, 0, 1, 0);
    chk("resume_pc", 64'(id_pc), 64'h84);
    cyc(0, 0, 1, 0, 1, 0);
    pushed = 0; popped = 0; n = 0;
    while (pushed < 3 * DEPTH && n < 500) begin
      cyc($urandom_range(0, 3) != 0, 32'h1000 + 32'(pushed * 4), $urandom_range(0, 2) != 0, 0, 1, 0);
      chk("wrap_bound", 64'(count <= 3'(DEPTH)), 1);
      n++;
    end
    while (mq.size() > 0 && n < 600) begin cyc(0, 0, 1, 0, 1, 0); n++; end
    chk("wrap_all_out", 64'(popped), 64'(3 * DEPTH));
    chk("wrap_empty", 64'(id_valid), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/if_id_queue.md
# if_id_queue

Parametrised instruction queue between the IF and ID stages of the RISC-V core. It generalises the single-entry IF/ID pipeline register to a DEPTH-entry FIFO with valid/ready handshakes on both sides, a synchronous flush for branch/jump redirects, and global `rdy` gating. When empty it presents a zero bubble (pc = 0, inst = 0) to ID.

## Interface
Parameters:
- DEPTH, 4: number of entries; power of two, ≥ 2.
- ADDR_W, 32: pc width (matches `InstAddrBus`).
- INST_W, 32: instruction width (matches `InstBus`).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset (`RstEnable` = 1).
- rdy  in  1  global ready; when 0 the queue holds all state.
- flush  in  1  discard all entries at the next edge.
- if_valid  in  1  IF presents an instruction.
- if_pc  in  ADDR_W  pc of offered instruction.
- if_inst  in  INST_W  offered instruction.
- if_ready  out  1  queue accepts an instruction this cycle.
- id_valid  out  1  head entry valid.
- id_pc  out  ADDR_W  head pc; 0 when empty.
- id_inst  out  INST_W  head instruction; 0 when empty.
- id_ready  in  1  ID consumes head this cycle.
- count  out  $clog2(DEPTH+1)  number of occupied entries.

## Operation
- State: storage[DEPTH], wr_ptr, rd_ptr (log2(DEPTH) bits, wrap modulo DEPTH), count.
- if_ready = (count != DEPTH). Independent of id_ready: no write-through when full.
- id_valid = (count != 0). id_pc/id_inst = storage[rd_ptr] when id_valid, else all-zero (bubble, same as the old stall insertion).
- push = if_valid & if_ready & rdy & !flush & !rst; pop = id_valid & id_ready & rdy & !flush & !rst.
- Edge priority: rst > flush (when rdy = 1) > push/pop.
- push: storage[wr_ptr] ← {if_pc, if_inst}; wr_ptr+1.
- pop: rd_ptr+1.
- count: +1 push only, −1 pop only, unchanged for both or neither.
- Simultaneous push+pop with 0 < count < DEPTH: both occur, count unchanged. With count = 0: push only (nothing to pop). With count = DEPTH: pop only (if_ready = 0).
- flush with rdy = 1: wr_ptr, rd_ptr, and count ← 0. The same-cycle offered instruction is dropped. flush with rdy = 0 is ignored.
- rdy = 0: no pointer, count or storage change. Outputs keep reflecting the held state.
- Storage contents need not be reset. Outputs are masked by id_valid.

## Timing
- Reset values: count = 0, if_ready = 1, id_valid = 0, id_pc = 0, id_inst = 0, pointers = 0.
- Latency: an instruction pushed at edge N appears on id_* after edge N (earliest ID use in cycle N+1). No combinational path from if_* to id_*.
- if_ready and id_valid depend only on registered count, so there are no combinational loops with producer/consumer.
- Throughput: one push and one pop per cycle sustained.
- Reset mid-stream: queue is empty the cycle after rst is sampled high, regardless of rdy or flush.
- Flush: id_valid = 0 and if_ready = 1 the cycle after the flush edge. A redirected pc pushed in that cycle is accepted normally.

## Structure
- Widths and constants (`ZeroWord`, `RstEnable`, `True_v`/`False_v`, `InstAddrBus`, `InstBus`) come from the shared defines.v. No new global constants.
- One natural sub-module: `fifo_mem` (DEPTH × (ADDR_W+INST_W) register array: write port with enable/address, asynchronous read port). The queue holds the pointers, count and control.

## Test plan
- Reset: hold rst = 1 for 2 cycles with if_valid = 1 → count = 0, id_valid = 0, id_pc = id_inst = 0, if_ready = 1.
- Fill/drain, DEPTH = 4, id_ready = 0: push pc 0x00,0x04,0x08,0x0C → count = 4, if_ready = 0, a 5th push is ignored. Then id_ready = 1 → id_pc 0x00,0x04,0x08,0x0C on successive cycles, then bubble.
- Streaming: if_valid = id_ready = 1 for 20 cycles with pc stepping by 4 → count stays at 1 after the first cycle, and id_pc lags if_pc by exactly one cycle with no drops.
- Flush: with 3 entries queued, assert flush alongside if_valid (pc 0x40) → next cycle count = 0 and id_valid = 0; pc 0x40 never appears. A push of pc 0x80 the following cycle appears at the head.
- rdy gating: with 2 entries queued, set rdy = 0 for 5 cycles with push, pop and flush all active → count, id_pc and id_inst stay unchanged. Resume with rdy = 1 → normal operation.
- Wrap-around: 3×DEPTH pushes and pops interleaved at random stall ratios → output order matches input order exactly, and count never exceeds DEPTH.
